// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool definitions: FSM encoding, word width and the 4-bit mini-boxes
// E, Einv and R used by both the forward and the inverse S-box.
package whirlpool_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] e_box(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'h1;  4'h1: r = 4'hB;  4'h2: r = 4'h9;  4'h3: r = 4'hC;
            4'h4: r = 4'hD;  4'h5: r = 4'h6;  4'h6: r = 4'hF;  4'h7: r = 4'h3;
            4'h8: r = 4'hE;  4'h9: r = 4'h8;  4'hA: r = 4'h7;  4'hB: r = 4'h4;
            4'hC: r = 4'hA;  4'hD: r = 4'h2;  4'hE: r = 4'h5;  default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] einv_box(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'hF;  4'h1: r = 4'h0;  4'h2: r = 4'hD;  4'h3: r = 4'h7;
            4'h4: r = 4'hB;  4'h5: r = 4'hE;  4'h6: r = 4'h5;  4'h7: r = 4'hA;
            4'h8: r = 4'h9;  4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h1;
            4'hC: r = 4'h3;  4'hD: r = 4'h4;  4'hE: r = 4'h8;  default: r = 4'h6;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] r_box(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'h0: r = 4'h7;  4'h1: r = 4'hC;  4'h2: r = 4'hB;  4'h3: r = 4'hD;
            4'h4: r = 4'hE;  4'h5: r = 4'h4;  4'h6: r = 4'h9;  4'h7: r = 4'hF;
            4'h8: r = 4'h6;  4'h9: r = 4'h3;  4'hA: r = 4'h8;  4'hB: r = 4'hA;
            4'hC: r = 4'h2;  4'hD: r = 4'h5;  4'hE: r = 4'h1;  default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/whirlpool_inv_sbox.sv
// Combinational Whirlpool inverse S-box built from the E/Einv/R mini-boxes.
import whirlpool_pkg::*;

module whirlpool_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] d;

    // Undo the forward output boxes first, then the shared R term cancels out.
    assign p = e_box(in_byte[3:0]);
    assign q = einv_box(in_byte[7:4]);
    assign d = r_box(p ^ q);

    assign out_byte = {einv_box(q ^ d), e_box(p ^ d)};

endmodule

// File: rtl/whirlpool_inv_sub_bytes.sv
// Inverse SubBytes for one 64-bit Whirlpool row, LANES bytes per cycle (LANES in 1,2,4,8).
import whirlpool_pkg::*;

module whirlpool_inv_sub_bytes #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int         STEPS    = 8 / LANES;
    localparam int         LANE_W   = 8 * LANES;
    localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   work_q, work_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [LANE_W-1:0]   sub_bytes;
    logic [WORD_W-1:0]   shifted;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        whirlpool_inv_sbox u_sbox (
            .in_byte  (work_q[8*gi +: 8]),
            .out_byte (sub_bytes[8*gi +: 8])
        );
    end

    // Results enter at the top, so after STEPS shifts every byte is back in place.
    if (LANES == 8) begin : g_full
        assign shifted = sub_bytes;
    end else begin : g_part
        assign shifted = {sub_bytes, work_q[WORD_W-1:LANE_W]};
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = 3'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d = shifted;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = work_q;

endmodule

// File: tb/tb_whirlpool_inv_sub_bytes.sv
// Scoreboard bench: four instances (LANES 1,2,4,8); drivers push expected rows, monitors pop and compare.
module tb_whirlpool_inv_sub_bytes;

    localparam logic [3:0] TE  [16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                                        4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
    localparam logic [3:0] TEI [16] = '{4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
                                        4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6};
    localparam logic [3:0] TR  [16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                                        4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a  [4];
    logic [63:0] in_data_a   [4];
    logic        out_ready_a [4];
    logic        in_ready_a  [4];
    logic        out_valid_a [4];
    logic        busy_a      [4];
    logic [63:0] out_data_a  [4];

    exp_t exp_q [4][$];
    int   last_hs [4];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_b;
    logic b_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int L = 1 << gi;

        whirlpool_inv_sub_bytes #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .in_data   (in_data_a[gi]),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready_a[gi]),
            .out_data  (out_data_a[gi]),
            .busy      (busy_a[gi])
        );

        initial begin : mon
            logic        prev_valid;
            logic [63:0] held;
            exp_t        e;
            prev_valid = 1'b0;
            held = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_valid = 1'b0;
                end else if (out_valid_a[gi]) begin
                    if (!prev_valid) begin
                        held = out_data_a[gi];
                        checks++;
                        if (exp_q[gi].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_output lanes=%0d got=%h", L, out_data_a[gi]);
                        end else if (cyc - exp_q[gi][0].acc != 8 / L) begin
                            errors++;
                            $display("FAIL latency lanes=%0d got=%0d want=%0d", L,
                                     cyc - exp_q[gi][0].acc, 8 / L);
                        end
                    end else begin
                        checks++;
                        if (out_data_a[gi] !== held) begin
                            errors++;
                            $display("FAIL out_data_stable lanes=%0d got=%h want=%h", L,
                                     out_data_a[gi], held);
                        end
                    end
                    if (out_ready_a[gi] && exp_q[gi].size() != 0) begin
                        e = exp_q[gi].pop_front();
                        last_hs[gi] = cyc + 1;
                        checks++;
                        if (out_data_a[gi] !== e.data) begin
                            errors++;
                            $display("FAIL data lanes=%0d got=%h want=%h", L, out_data_a[gi], e.data);
                        end
                        $display("lanes=%0d result %h accepted@%0d", L, out_data_a[gi], e.acc);
                    end
                    prev_valid = !out_ready_a[gi];
                end else begin
                    prev_valid = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] fwd(input logic [7:0] x);
        logic [3:0] a, b, r;
        a = TE[x[7:4]];
        b = TEI[x[3:0]];
        r = TR[a ^ b];
        return {TE[a ^ r], TEI[b ^ r]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Called just after a rising edge; returns once the word has been accepted.
    task automatic send(input int d, input logic [63:0] data, input logic [63:0] expv, output int acc);
        int waited;
        waited = 0;
        in_valid_a[d] = 1'b1;
        in_data_a[d]  = data;
        while (!in_ready_a[d] && waited < 200) begin
            step();
            waited++;
        end
        if (waited >= 200) begin
            errors++;
            $display("FAIL accept_timeout dut=%0d got=in_ready_low want=accept", d);
            in_valid_a[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        exp_q[d].push_back('{expv, acc});
        $display("dut=%0d send %h expect %h edge=%0d", d, data, expv, acc);
        step();
        in_valid_a[d] = 1'b0;
        in_data_a[d]  = ~data;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (exp_q[d].size() != 0) begin
            errors++;
            $display("FAIL drain_timeout dut=%0d got=%0d pending want=0", d, exp_q[d].size());
            exp_q[d].delete();
        end
    endtask

    task automatic rt_word(input int k, output logic [63:0] win, output logic [63:0] wexp);
        logic [7:0] x;
        for (int j = 0; j < 8; j++) begin
            x = 8'(8 * k + j);
            win[63 - 8*j -: 8]  = fwd(x);
            wexp[63 - 8*j -: 8] = x;
        end
    endtask

    initial begin
        int          acc, prev, n;
        logic [63:0] win, wexp;

        rst = 1'b1;
        b_done = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_valid_a[d]  = 1'b1;
            in_data_a[d]   = 64'h1823C6E887B8014F;
            out_ready_a[d] = 1'b1;
            last_hs[d]     = 0;
        end
        repeat (3) step();
        for (int d = 0; d < 4; d++) begin
            chk("rst_in_ready", 64'(in_ready_a[d]), 64'd1);
            chk("rst_out_valid", 64'(out_valid_a[d]), 64'd0);
            chk("rst_busy", 64'(busy_a[d]), 64'd0);
            chk("rst_out_data", out_data_a[d], 64'd0);
        end
        rst = 1'b0;
        for (int d = 0; d < 4; d++) in_valid_a[d] = 1'b0;
        step();
        chk("no_accept_in_reset", 64'(busy_a[1]), 64'd0);

        // Known vectors: 18->00, 23->01, 01->06 and the first forward S-box row.
        send(1, 64'h1823C6E887B8014F, 64'h0001020304050607, acc);
        send(1, 64'h1823011818231801, 64'h0001060000010006, acc);
        drain(1);
        send(3, 64'h1823C6E887B8014F, 64'h0001020304050607, acc);
        send(3, 64'h0118231801231823, 64'h0600010006010001, acc);
        drain(3);

        // Back-to-back with in_valid and out_ready held high.
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            rt_word(k + 7, win, wexp);
            send(1, win, wexp, acc);
            if (k > 0) chk("b2b_spacing", 64'(acc - prev), 64'd6);
            prev = acc;
        end
        drain(1);

        // Backpressure: hold out_ready low, second word must wait for the handshake.
        out_ready_a[1] = 1'b0;
        send(1, 64'h1823C6E887B8014F, 64'h0001020304050607, acc);
        b_done = 1'b0;
        fork
            begin
                rt_word(3, win, wexp);
                send(1, win, wexp, acc_b);
                b_done = 1'b1;
            end
        join_none
        n = 0;
        while (!out_valid_a[1] && n < 50) begin
            step();
            n++;
        end
        chk("bp_out_valid", 64'(out_valid_a[1]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", 64'(in_ready_a[1]), 64'd0);
            chk("bp_not_accepted", 64'(b_done), 64'd0);
            step();
        end
        out_ready_a[1] = 1'b1;
        n = 0;
        while (!b_done && n < 50) begin
            step();
            n++;
        end
        chk("bp_second_accept_edge", 64'(acc_b), 64'(last_hs[1] + 1));
        drain(1);

        // Reset during the second BUSY cycle discards the word.
        send(1, 64'h0123456789ABCDEF, 64'h0, acc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q[1].delete();
        chk("abort_in_ready", 64'(in_ready_a[1]), 64'd1);
        chk("abort_out_valid", 64'(out_valid_a[1]), 64'd0);
        chk("abort_busy", 64'(busy_a[1]), 64'd0);
        chk("abort_out_data", out_data_a[1], 64'd0);
        send(1, 64'h1823C6E887B8014F, 64'h0001020304050607, acc);
        drain(1);

        // Round trip of all 256 bytes through every lane count.
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 32; k++) begin
                rt_word(k, win, wexp);
                send(d, win, wexp, acc);
            end
            drain(d);
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/whirlpool_inv_sub_bytes.md
WHIRLPOOL_INV_SUB_BYTES -- requirements
Module: whirlpool_inv_sub_bytes

Interface
REQ-001 The block SHALL have parameter LANES, default 2: number of inverse S-box instances; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 64: one Whirlpool state row; byte 0 is bits [63:56].
REQ-007 The block SHALL have port out_valid, output, 1: out_data holds a completed result.
REQ-008 The block SHALL have port out_ready, input, 1: downstream takes the result this cycle.
REQ-009 The block SHALL have port out_data, output, 64: inverse-substituted row, in the same byte order as in_data.
REQ-010 The block SHALL have port busy, output, 1: asserted in BUSY state.

Function
REQ-011 Each output byte SHALL be the Whirlpool inverse S-box of the corresponding input byte, so that S(out) = in.
REQ-012 The inverse for input byte y SHALL be computed through the mini-box structure as follows:
- p = E(y[3:0]) and q = Einv(y[7:4]).
- c = p^q and d = R(c).
- x[3:0] = E(p^d) and x[7:4] = Einv(q^d).
- E, Einv and R are the Whirlpool 4-bit mini-boxes.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in_valid&in_ready SHALL load in_data into the 64-bit work register, clear the lane counter and go to BUSY.
REQ-015 In BUSY, each cycle the block SHALL substitute the LANES least-significant bytes of the work register, shift the register right by 8*LANES bits and insert the results at the top.
REQ-016 The lane counter (3 bits) SHALL increment every BUSY cycle; after 8/LANES cycles the FSM SHALL go to DONE.
REQ-017 For LANES=8, BUSY SHALL last exactly one cycle.
REQ-018 Latency: acceptance at edge t SHALL give out_valid=1 after edge t+8/LANES (LANES=2: 4 cycles).
REQ-019 In DONE, out_valid SHALL be 1 and out_data SHALL hold stable until out_valid&out_ready; on that handshake the FSM SHALL go to IDLE.
REQ-020 in_ready SHALL be 0 in BUSY and DONE; in_valid in those states SHALL be ignored and nothing SHALL be dropped or queued, so upstream holds its word.
REQ-021 No new word SHALL be accepted in the DONE→IDLE handshake cycle; the next acceptance is the following cycle at the earliest.
REQ-022 Throughput SHALL be one word per 8/LANES+2 cycles with out_ready held high.
REQ-023 out_ready in IDLE or BUSY SHALL have no effect.
REQ-024 in_data changing while not accepted SHALL have no effect.
REQ-025 out_data SHALL be driven directly from the work register; outside DONE its value is don't-care for consumers.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, lane counter 0 and work register 0 in any state, including mid-BUSY or DONE; an in-flight word SHALL be discarded.
REQ-027 Reset values SHALL be in_ready=1, out_valid=0, busy=0, out_data=64'h0.
REQ-028 in_valid during the reset cycle SHALL NOT be accepted.

Structure
REQ-029 A shared package whirlpool_pkg SHALL hold the FSM state encoding, the word width constant (64) and the 4-bit mini-box tables E, Einv and R as constant functions, shared with the forward S-box.
REQ-030 One purely combinational sub-module, whirlpool_inv_sbox (8-bit in, 8-bit out, REQ-012 datapath), SHALL be instantiated LANES times.
REQ-031 There SHALL be no memories and no multi-cycle paths.

Verification
REQ-032 Known vectors: inverse S-box inputs 0x18→0x00, 0x23→0x01, 0x01→0x06, checked through whirlpool_inv_sbox.
REQ-033 Full-word check with LANES=2: in_data=0x1823C6E887B8014F → out_data=0x0001020304050607, out_valid exactly 4 cycles after acceptance.
REQ-034 Exhaustive round-trip: all 256 bytes through the forward S-box, then this block (8 bytes per word) SHALL return the original bytes; repeat for LANES=1, 2, 4, 8.
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0 and a second in_valid word not accepted until the cycle after the handshake.
REQ-036 Reset in the 2nd BUSY cycle → next cycle IDLE, out_valid=0, out_data=0; a fresh word then completes correctly.
REQ-037 Back-to-back words with out_ready=1 and in_valid=1 constantly (LANES=2) → one result every 6 cycles, all correct.
